fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch stage between the instruction memory and the IF/ID latch of the pipelined KGP-RISC core. It owns the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory. Fetched words are queued in a small circular buffer, and each word is presented to IF/ID together with its PC and PC+4. Branch/jump redirects from ID flush the queue and discard any in-flight response.

## Interface
- `DEPTH`, 4 — queue entries; power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000 — fetch PC loaded at reset; word aligned.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `imem_req` out 1 — fetch request, held until `imem_ack`.
- `imem_addr` out 32 — fetch address, stable while `imem_req` is high.
- `imem_ack` in 1 — response valid this cycle; ignored when no request is outstanding.
- `imem_rdata` in 32 — instruction word, valid with `imem_ack`.
- `redirect` in 1 — taken branch/jump (pcsrc) from ID.
- `redirect_pc` in 32 — target address (pcbranch); bits [1:0] are forced to 0.
- `if_id_write` in 1 — IF/ID accept; low means stall.
- `out_valid` out 1 — queue head is valid.
- `out_instr` out 32 — head instruction.
- `out_pc` out 32 — head PC.
- `out_npc` out 32 — head PC+4, modulo 2^32.
- `buf_count` out clog2(DEPTH)+1 — occupied entries.

## Operation
- FSM states: IDLE, FETCH, FULL, DROP.
  - IDLE: reset state. Moves to FETCH unconditionally on the next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=fpc. On `imem_ack`: push {fpc, rdata} and set fpc←fpc+4. If the post-cycle count equals DEPTH, go to FULL; else stay in FETCH and issue the next request in the following cycle.
  - FULL: `imem_req`=0. Returns to FETCH in the cycle after count drops below DEPTH.
  - DROP: `imem_req`=1, `imem_addr` held at the abandoned address. On `imem_ack`: discard the data and go to FETCH using the new fpc.
- Request rule: at most one outstanding request. A request is only started when count < DEPTH, so an ack always has room.
- Pop: occurs when `out_valid` and `if_id_write` are both high. The head advances on the clock edge.
- Redirect takes priority over push and pop in the same cycle:
  - count←0 and fpc←{redirect_pc[31:2],2'b00}.
  - A pop in that cycle is not performed; the IF/ID write is ID's concern.
  - If a request is outstanding and the ack does not arrive in this same cycle, go to DROP.
  - If the ack arrives in the redirect cycle, discard its data and go to FETCH.
  - If no request is outstanding (IDLE, FULL, FETCH before first issue), go to FETCH.
- Redirect while in DROP: update fpc and stay in DROP.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. fpc wraps modulo 2^32.
- Mid-operation reset: all state is cleared immediately (asynchronous). Any outstanding memory response after reset release is ignored, because IDLE holds `imem_req` low.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_npc`=0
  - `buf_count`=0
- First `imem_req` is asserted in the second cycle after reset deassertion.
- Ack→`out_valid` latency: 1 cycle (registered queue). Zero-latency path is available only under the bypass configuration.
- Redirect→`imem_req` with the new address:
  - next cycle if no request is outstanding;
  - otherwise the cycle after the discarded ack.
- With a 1-cycle memory and no stalls, sustained throughput is one instruction every 2 cycles (request, ack).

## Configuration
- `FETCH_BUF_BYPASS_EN` defined:
  - When the queue is empty and `imem_ack` arrives, the word appears on `out_*` in the same cycle with `out_valid`=1.
  - If `if_id_write`=1 in that cycle, the word is consumed without being written to the queue.
  - A redirect in that cycle suppresses the bypass.
- Undefined: `out_*` is driven only from registered queue storage, with no combinational path from `imem_rdata` to `out_instr`.

## Structure
- Package `fetch_pkg`:
  - FSM state enum (IDLE, FETCH, FULL, DROP)
  - `INSTR_W`=32, `PC_INC`=32'd4
  - default `RESET_PC`
- Sub-module `fetch_fifo`:
  - DEPTH-entry circular buffer of {pc, instr}
  - push, pop and flush inputs; head outputs and count
  - flush takes priority over push and pop
- The top level holds the fetch PC, the FSM, the redirect logic and the bypass mux.

## Test plan
- **Reset/streaming:** 1-cycle ack memory, RESET_PC=0, `if_id_write`=1 → `imem_addr` sequence 0,4,8; `out_pc`/`out_npc` pairs 0/4, 4/8, 8/12; `out_valid` rises 1 cycle after the first ack.
- **Full:** `if_id_write`=0, DEPTH=4 → after 4 acks `buf_count`=4, `imem_req`=0. Raise `if_id_write` for 1 cycle → `imem_req`=1 with addr 0x10 the following cycle.
- **Redirect with outstanding request:** ack latency 3; assert `redirect` to 0x40 while the request for 0x8 is pending → `buf_count`=0 next cycle; the ack for 0x8 is discarded; the next request goes to 0x40; the first `out_pc`=0x40.
- **Simultaneous redirect and ack:** `redirect` to 0x103 in the ack cycle → ack data dropped; next `imem_addr`=0x100.
- **Asynchronous reset mid-DROP:** `buf_count`=0 and `imem_req`=0 without a clock edge; restart at RESET_PC.
- **`FETCH_BUF_BYPASS_EN`:** empty queue with ack of 0xDEADBEEF → `out_valid`=1 and `out_instr`=0xDEADBEEF in the same cycle; `buf_count` stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction prefetch buffer:
//            fetch FSM state encoding, queue entry layout, PC increment and
//            the default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    // One queued fetch: the word and the address it was read from
    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry circular buffer of {pc, instr}. Flush empties the
//            buffer and overrides any push or pop in the same cycle. Head
//            entry and occupancy are presented combinationally from the
//            registered storage.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  fetch_entry_t     wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Never write into a full buffer nor read from an empty one; flush wins
    assign do_push = push_i & ~flush_i & (count_q != FULL_CNT);
    assign do_pop  = pop_i  & ~flush_i & (count_q != '0);

    // Next pointer/occupancy: pointers wrap naturally since DEPTH is 2^AW
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared at reset so the head reads as zero when empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction prefetch stage. Owns the fetch PC, issues one
//            request at a time to a variable-latency instruction memory,
//            queues returned words and presents {instr, pc, pc+4} to IF/ID.
//            Redirects from ID flush the queue and abandon any in-flight
//            response.
// Options  : FETCH_BUF_BYPASS_EN - when defined, an ack arriving on an empty
//            queue is forwarded to out_* in the same cycle (and consumed
//            directly when IF/ID accepts). Undefined: out_* come only from
//            queue registers.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic                    if_id_write,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_npc,
    output logic [$clog2(DEPTH):0]  buf_count
);

    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] fpc_q, fpc_d;
    logic [INSTR_W-1:0] drop_addr_q, drop_addr_d;

    fetch_entry_t       fifo_head;
    fetch_entry_t       fifo_wdata;
    logic               fifo_valid;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_post;
    logic               ack_live;
    logic               bypass_take;

    // Only an ack to a live FETCH request carries a word we keep; an ack
    // seen in DROP belongs to an abandoned address.
    assign ack_live = (state_q == FETCH) & imem_ack;

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = ack_live & ~redirect & ~fifo_valid;
    assign bypass_take = bypass_hit & if_id_write;
`else
    assign bypass_take = 1'b0;
`endif

    assign fifo_wdata = {fpc_q, imem_rdata};
    assign fifo_push  = ack_live & ~redirect & ~bypass_take;
    assign fifo_pop   = fifo_valid & if_id_write & ~redirect;
    assign count_post = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign buf_count = fifo_count;

    // Fetch sequencer: next state, fetch PC and memory request outputs
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        imem_req    = 1'b0;
        imem_addr   = fpc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // Ack in the redirect cycle closes the request; otherwise
                    // wait out the abandoned response in DROP.
                    if (!imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = fpc_q;
                    end
                end else if (imem_ack) begin
                    fpc_d = fpc_q + PC_INC;
                    if (count_post == FULL_CNT) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect || fifo_pop) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            fpc_d = word_align(redirect_pc);
        end
    end

    // Sequencer state, fetch PC and held abandoned address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // IF/ID presentation: queue head first, bypassed ack only on empty queue
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        out_npc   = '0;
        if (fifo_valid) begin
            out_valid = 1'b1;
            out_instr = fifo_head.instr;
            out_pc    = fifo_head.pc;
            out_npc   = fifo_head.pc + PC_INC;
        end
`ifdef FETCH_BUF_BYPASS_EN
        else if (bypass_hit) begin
            out_valid = 1'b1;
            out_instr = imem_rdata;
            out_pc    = fpc_q;
            out_npc   = fpc_q + PC_INC;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer with a variable-latency
//            memory model and an expected-PC scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_write = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [2:0]  buf_count;

    int          n_pass = 0;
    int          n_total = 0;
    int          mem_lat = 1;
    int          mem_age = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_addr_q[$];

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_write (if_id_write),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_npc     (out_npc),
        .buf_count   (buf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: acks a held request after mem_lat request cycles; one ack per request
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            imem_ack = 1'b0;
            mem_age  = 0;
        end else if (stray_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
        end else begin
            if (imem_ack) begin
                imem_ack = 1'b0;
                mem_age  = 0;
            end
            if (imem_req) begin
                if (mem_age >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_data(imem_addr);
                end else begin
                    mem_age++;
                end
            end else begin
                mem_age = 0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; if_id_write = 1'b0;
        exp_pc_q.delete(); exp_addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== RST_PC) $display("FAIL rst_addr got %h want %h", imem_addr, RST_PC); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", out_instr); else n_pass++;
        n_total++; if (out_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", out_pc); else n_pass++;
        n_total++; if (out_npc !== 32'h0) $display("FAIL rst_npc got %h want 0", out_npc); else n_pass++;
        n_total++; if (buf_count !== 3'd0) $display("FAIL rst_count got %0d want 0", buf_count); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else n_pass++;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== RST_PC) $display("FAIL first_addr got %h want %h", imem_addr, RST_PC); else n_pass++;
    endtask

    task automatic test_streaming();
        int          cyc;
        int          first_ack;
        int          first_valid;
        int          lat_exp;
        logic [31:0] ep;
        logic [31:0] ea;
        apply_reset();
        mem_lat = 1; if_id_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_pc_q.push_back(32'(k * 4));
            exp_addr_q.push_back(32'(k * 4));
        end
        first_ack = -1; first_valid = -1; cyc = 0;
        while (exp_pc_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                if (first_ack < 0) first_ack = cyc;
                if (exp_addr_q.size() > 0) begin
                    ea = exp_addr_q.pop_front();
                    n_total++; if (imem_addr !== ea) $display("FAIL stream_addr got %h want %h", imem_addr, ea); else n_pass++;
                end
            end
            if (out_valid && if_id_write) begin
                if (first_valid < 0) first_valid = cyc;
                ep = exp_pc_q.pop_front();
                n_total++; if (out_pc !== ep) $display("FAIL stream_pc got %h want %h", out_pc, ep); else n_pass++;
                n_total++; if (out_npc !== ep + 32'd4) $display("FAIL stream_npc got %h want %h", out_npc, ep + 32'd4); else n_pass++;
                n_total++; if (out_instr !== mem_data(ep)) $display("FAIL stream_instr got %h want %h", out_instr, mem_data(ep)); else n_pass++;
            end
            cyc++;
        end
        n_total++; if (exp_pc_q.size() != 0) $display("FAIL stream_timeout left %0d want 0", exp_pc_q.size()); else n_pass++;
`ifdef FETCH_BUF_BYPASS_EN
        lat_exp = 0;
`else
        lat_exp = 1;
`endif
        n_total++;
        if (first_valid - first_ack != lat_exp) $display("FAIL stream_latency got %0d want %0d", first_valid - first_ack, lat_exp);
        else n_pass++;
        if_id_write = 1'b0;
    endtask

    task automatic test_full();
        int cyc;
        apply_reset();
        mem_lat = 1; if_id_write = 1'b0; cyc = 0;
        while (buf_count !== 3'd4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (buf_count !== 3'd4) $display("FAIL full_count got %0d want 4", buf_count); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL full_req got %b want 0", imem_req); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (imem_req !== 1'b0) $display("FAIL full_hold_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (out_pc !== 32'h0) $display("FAIL full_head got %h want 0", out_pc); else n_pass++;
        if_id_write = 1'b1;
        @(negedge clk);
        if_id_write = 1'b0;
        n_total++; if (imem_req !== 1'b1) $display("FAIL refill_req got %b want 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h10) $display("FAIL refill_addr got %h want 10", imem_addr); else n_pass++;
        n_total++; if (buf_count !== 3'd3) $display("FAIL refill_count got %0d want 3", buf_count); else n_pass++;
        n_total++; if (out_pc !== 32'h4) $display("FAIL refill_head got %h want 4", out_pc); else n_pass++;
    endtask

    task automatic test_redirect_outstanding();
        int          cyc;
        logic        seen_drop;
        logic        post_drop;
        logic [31:0] ep;
        apply_reset();
        mem_lat = 3; if_id_write = 1'b0; cyc = 0;
        while (!(imem_req && imem_addr == 32'h8) && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (imem_addr !== 32'h8) $display("FAIL rdo_wait got %h want 8", imem_addr); else n_pass++;
        n_total++; if (buf_count !== 3'd2) $display("FAIL rdo_pre_count got %0d want 2", buf_count); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        n_total++; if (buf_count !== 3'd0) $display("FAIL rdo_flush got %0d want 0", buf_count); else n_pass++;
        n_total++; if (imem_addr !== 32'h8) $display("FAIL rdo_hold_addr got %h want 8", imem_addr); else n_pass++;
        if_id_write = 1'b1;
        exp_pc_q.push_back(32'h40);
        exp_pc_q.push_back(32'h44);
        seen_drop = 1'b0; post_drop = 1'b0; cyc = 0;
        while (exp_pc_q.size() > 0 && cyc < 80) begin
            @(negedge clk);
            if (post_drop) begin
                post_drop = 1'b0;
                n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rdo_new_req got %b/%h want 1/40", imem_req, imem_addr); else n_pass++;
                n_total++; if (buf_count !== 3'd0) $display("FAIL rdo_discard got %0d want 0", buf_count); else n_pass++;
            end
            if (imem_ack && !seen_drop) begin
                seen_drop = 1'b1; post_drop = 1'b1;
                n_total++; if (imem_addr !== 32'h8) $display("FAIL rdo_drop_addr got %h want 8", imem_addr); else n_pass++;
            end
            if (out_valid && if_id_write) begin
                ep = exp_pc_q.pop_front();
                n_total++; if (out_pc !== ep) $display("FAIL rdo_pc got %h want %h", out_pc, ep); else n_pass++;
                n_total++; if (out_instr !== mem_data(ep)) $display("FAIL rdo_instr got %h want %h", out_instr, mem_data(ep)); else n_pass++;
            end
            cyc++;
        end
        n_total++; if (exp_pc_q.size() != 0) $display("FAIL rdo_timeout left %0d want 0", exp_pc_q.size()); else n_pass++;
        if_id_write = 1'b0;
    endtask

    task automatic test_redirect_ack();
        int cyc;
        apply_reset();
        mem_lat = 1; if_id_write = 1'b0; cyc = 0;
        while (!imem_ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (imem_ack !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rda_wait got %b/%h want 1/0", imem_ack, imem_addr); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rda_no_bypass got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        n_total++; if (buf_count !== 3'd0) $display("FAIL rda_dropped got %0d want 0", buf_count); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rda_addr got %b/%h want 1/100", imem_req, imem_addr); else n_pass++;
        if_id_write = 1'b1; cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (out_pc !== 32'h100) $display("FAIL rda_first_pc got %h want 100", out_pc); else n_pass++;
        n_total++; if (out_instr !== mem_data(32'h100)) $display("FAIL rda_instr got %h want %h", out_instr, mem_data(32'h100)); else n_pass++;
        if_id_write = 1'b0;
    endtask

    task automatic test_reset_drop();
        int cyc;
        apply_reset();
        mem_lat = 2; if_id_write = 1'b0; cyc = 0;
        while (!(imem_req && imem_addr == 32'h8) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || imem_ack !== 1'b0) $display("FAIL ard_in_drop got %b/%h want 1/8", imem_req, imem_addr); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (buf_count !== 3'd0) $display("FAIL ard_count got %0d want 0", buf_count); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL ard_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== RST_PC) $display("FAIL ard_addr got %h want %h", imem_addr, RST_PC); else n_pass++;
        stray_ack = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        n_total++; if (imem_req !== 1'b0 || out_valid !== 1'b0) $display("FAIL ard_idle got %b/%b want 0/0", imem_req, out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (buf_count !== 3'd0) $display("FAIL ard_stray got %0d want 0", buf_count); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) $display("FAIL ard_restart got %b/%h want 1/%h", imem_req, imem_addr, RST_PC); else n_pass++;
        if_id_write = 1'b1; cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (out_pc !== RST_PC || out_instr !== mem_data(RST_PC)) $display("FAIL ard_first got %h/%h want %h", out_pc, out_instr, RST_PC); else n_pass++;
        if_id_write = 1'b0;
    endtask

    task automatic test_bypass();
        int cyc;
        apply_reset();
        mem_lat = 1; if_id_write = 1'b1; cyc = 0;
        while (!imem_ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
`ifdef FETCH_BUF_BYPASS_EN
        n_total++; if (out_valid !== 1'b1) $display("FAIL byp_valid got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_instr !== 32'hDEAD_BEEF) $display("FAIL byp_instr got %h want deadbeef", out_instr); else n_pass++;
        @(negedge clk);
        n_total++; if (buf_count !== 3'd0) $display("FAIL byp_count got %0d want 0", buf_count); else n_pass++;
`else
        n_total++; if (out_valid !== 1'b0) $display("FAIL nobyp_valid got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (buf_count !== 3'd1) $display("FAIL nobyp_count got %0d want 1", buf_count); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_instr !== 32'hDEAD_BEEF) $display("FAIL nobyp_instr got %b/%h want 1/deadbeef", out_valid, out_instr); else n_pass++;
`endif
        if_id_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_redirect_outstanding();
        test_redirect_ack();
        test_reset_drop();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
